dram_arbiter: RTL and testbench

- Owns the DRAM cycle grid and generates the four phase strobes consumed by the Z80 memory manager: cbeg, post_cbeg, pre_cend, cend.
- Shares each 4-fclk DRAM cycle between three requesters, in priority order: video fetch (hard reservation), CPU, DMA.
- Muxes the winner's address and data onto the DRAM controller port and returns read strobes to the winner.
- DMA has a starvation guard so it cannot be locked out by a continuous CPU stream.

---
 rtl/dram_arbiter_pkg.sv | 26 ++
 rtl/dram_arbiter_phase_gen.sv | 26 ++
 rtl/dram_arbiter.sv | 155 +++++++++++++++
 tb/tb_dram_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types for the DRAM arbiter, the DRAM controller and their tests:
// cycle-owner encoding and the four-phase DRAM cycle grid.
package dram_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  localparam logic [1:0] PH_CBEG      = 2'd0;
  localparam logic [1:0] PH_POST_CBEG = 2'd1;
  localparam logic [1:0] PH_PRE_CEND  = 2'd2;
  localparam logic [1:0] PH_CEND      = 2'd3;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 16;

  // Byte enables for a CPU access: reads take the whole word, writes one lane.
  function automatic logic [1:0] cpu_bsel(input logic rnw, input logic wrbsel);
    if (rnw) return 2'b11;
    return wrbsel ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/dram_arbiter_phase_gen.sv
// DRAM cycle grid: free-running 2-bit phase counter decoded into four
// one-hot phase strobes. Reset parks on cend so the first edge is a decision.
module dram_phase_gen
  import dram_arbiter_pkg::*;
(
  input  logic fclk,
  input  logic rst_n,
  output logic o_cbeg,
  output logic o_post_cbeg,
  output logic o_pre_cend,
  output logic o_cend
);

  logic [1:0] r_phase;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) r_phase <= PH_CEND;
    else        r_phase <= r_phase + 2'd1;
  end

  assign o_cbeg      = (r_phase == PH_CBEG);
  assign o_post_cbeg = (r_phase == PH_POST_CBEG);
  assign o_pre_cend  = (r_phase == PH_PRE_CEND);
  assign o_cend      = (r_phase == PH_CEND);

endmodule

// File: rtl/dram_arbiter.sv
// Shares each 4-fclk DRAM cycle between video (reserved slots), CPU and DMA,
// with a starvation guard that lets DMA beat a continuous CPU stream.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int DMA_MAXWAIT = 8
) (
  input  logic              fclk,
  input  logic              rst_n,
  output logic              cbeg,
  output logic              post_cbeg,
  output logic              pre_cend,
  output logic              cend,
  input  logic              vid_slot,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_strobe,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wrdata,
  input  logic              cpu_wrbsel,
  output logic              cpu_next,
  output logic              cpu_strobe,
  input  logic              dma_req,
  input  logic              dma_rnw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wrdata,
  output logic              dma_ack,
  output logic              dma_strobe,
  output logic              dram_req,
  output logic              dram_rnw,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wrdata,
  output logic [1:0]        dram_bsel,
  input  logic [DATA_W-1:0] dram_rddata,
  output logic [DATA_W-1:0] rddata
);

  localparam logic [3:0] MAXWAIT = 4'(DMA_MAXWAIT);

  owner_e            r_owner;
  owner_e            w_owner_next;
  owner_e            w_winner;
  logic [3:0]        r_wait_cnt;
  logic              w_dma_force;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic              r_rnw, w_rnw;
  logic [DATA_W-1:0] r_wrdata, w_wrdata;
  logic [1:0]        r_bsel, w_bsel;
  logic [DATA_W-1:0] r_rddata;
  logic              w_read_end;

  dram_phase_gen u_phase_gen (
    .fclk        (fclk),
    .rst_n       (rst_n),
    .o_cbeg      (cbeg),
    .o_post_cbeg (post_cbeg),
    .o_pre_cend  (pre_cend),
    .o_cend      (cend)
  );

  assign w_dma_force = dma_req && (r_wait_cnt >= MAXWAIT);
  assign cpu_next    = !vid_slot && !w_dma_force;

  always_comb begin
    w_winner = OWN_IDLE;
    if (vid_slot)         w_winner = OWN_VID;
    else if (w_dma_force) w_winner = OWN_DMA;
    else if (cpu_req)     w_winner = OWN_CPU;
    else if (dma_req)     w_winner = OWN_DMA;
  end

  // Owner and the winner's request are latched together at cend so the
  // DRAM port stays stable for the whole owned cycle.
  always_comb begin
    w_owner_next = r_owner;
    w_addr       = r_addr;
    w_rnw        = r_rnw;
    w_wrdata     = r_wrdata;
    w_bsel       = r_bsel;
    if (cend) begin
      w_owner_next = w_winner;
      case (w_winner)
        OWN_VID: begin
          w_addr = vid_addr;
          w_rnw  = 1'b1;
          w_bsel = 2'b11;
        end
        OWN_CPU: begin
          w_addr   = cpu_addr;
          w_rnw    = cpu_rnw;
          w_wrdata = {cpu_wrdata, cpu_wrdata};
          w_bsel   = cpu_bsel(cpu_rnw, cpu_wrbsel);
        end
        OWN_DMA: begin
          w_addr   = dma_addr;
          w_rnw    = dma_rnw;
          w_wrdata = dma_wrdata;
          w_bsel   = 2'b11;
        end
        default: begin
          w_rnw  = 1'b1;
          w_bsel = 2'b11;
        end
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= OWN_IDLE;
      r_addr   <= '0;
      r_rnw    <= 1'b1;
      r_wrdata <= '0;
      r_bsel   <= 2'b11;
    end else begin
      r_owner  <= w_owner_next;
      r_addr   <= w_addr;
      r_rnw    <= w_rnw;
      r_wrdata <= w_wrdata;
      r_bsel   <= w_bsel;
    end
  end

  // Counts consecutive lost arbitrations; video wins also count so a forced
  // DMA grant survives a reserved slot.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (cend) begin
      if (!dma_req || w_winner == OWN_DMA) r_wait_cnt <= 4'd0;
      else if (r_wait_cnt != 4'hF)         r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  assign w_read_end = cend && r_rnw;

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n)                                r_rddata <= '0;
    else if (w_read_end && r_owner != OWN_IDLE) r_rddata <= dram_rddata;
  end

  assign dram_req    = (r_owner != OWN_IDLE);
  assign dram_rnw    = r_rnw;
  assign dram_addr   = r_addr;
  assign dram_wrdata = r_wrdata;
  assign dram_bsel   = r_bsel;
  assign rddata      = r_rddata;

  assign vid_strobe = w_read_end && (r_owner == OWN_VID);
  assign cpu_strobe = w_read_end && (r_owner == OWN_CPU);
  assign dma_strobe = w_read_end && (r_owner == OWN_DMA);
  assign dma_ack    = cend && (w_winner == OWN_DMA);

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: a table of per-DRAM-cycle vectors
// checked through a scoreboard, plus reset and mid-cycle reset sequences.
`timescale 1ns/1ps
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  typedef struct {
    int          id;
    logic        vid;
    logic [20:0] vaddr;
    logic        creq;
    logic        crnw;
    logic        cbsel;
    logic [20:0] caddr;
    logic [7:0]  cdata;
    logic        dreq;
    logic        drnw;
    logic [20:0] daddr;
    logic [15:0] ddata;
    logic [15:0] rdd;
    logic        eNext;
    logic        eAck;
    owner_e      eOwn;
    logic [20:0] eAddr;
    logic        eRnw;
    logic [1:0]  eBsel;
    logic [15:0] eWr;
  } vec_t;

  logic        fclk, rst_n;
  logic        cbeg, post_cbeg, pre_cend, cend;
  logic        vid_slot, vid_strobe;
  logic [20:0] vid_addr;
  logic        cpu_req, cpu_rnw, cpu_wrbsel, cpu_next, cpu_strobe;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        dma_req, dma_rnw, dma_ack, dma_strobe;
  logic [20:0] dma_addr;
  logic [15:0] dma_wrdata;
  logic        dram_req, dram_rnw;
  logic [20:0] dram_addr;
  logic [15:0] dram_wrdata, dram_rddata, rddata;
  logic [1:0]  dram_bsel;

  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  expPhase;
  logic [15:0] expRddata;
  vec_t        tbl[$];
  vec_t        sb[$];

  dram_arbiter #(.DMA_MAXWAIT(8)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .cbeg(cbeg), .post_cbeg(post_cbeg), .pre_cend(pre_cend), .cend(cend),
    .vid_slot(vid_slot), .vid_addr(vid_addr), .vid_strobe(vid_strobe),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrdata(cpu_wrdata), .cpu_wrbsel(cpu_wrbsel),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe),
    .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr),
    .dma_wrdata(dma_wrdata), .dma_ack(dma_ack), .dma_strobe(dma_strobe),
    .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr),
    .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel),
    .dram_rddata(dram_rddata), .rddata(rddata)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic vid, input logic [20:0] vaddr,
                        input logic creq, input logic crnw, input logic cbsel,
                        input logic [20:0] caddr, input logic [7:0] cdata,
                        input logic dreq, input logic drnw, input logic [20:0] daddr,
                        input logic [15:0] ddata, input logic [15:0] rdd,
                        input logic eNext, input logic eAck, input owner_e eOwn,
                        input logic [20:0] eAddr, input logic eRnw,
                        input logic [1:0] eBsel, input logic [15:0] eWr);
    vec_t v;
    v.id = tbl.size(); v.vid = vid; v.vaddr = vaddr;
    v.creq = creq; v.crnw = crnw; v.cbsel = cbsel; v.caddr = caddr; v.cdata = cdata;
    v.dreq = dreq; v.drnw = drnw; v.daddr = daddr; v.ddata = ddata; v.rdd = rdd;
    v.eNext = eNext; v.eAck = eAck; v.eOwn = eOwn; v.eAddr = eAddr;
    v.eRnw = eRnw; v.eBsel = eBsel; v.eWr = eWr;
    tbl.push_back(v);
  endtask

  task automatic addIdle();
    addVec(0, 21'h0, 0, 1, 0, 21'h0, 8'h00, 0, 1, 21'h0, 16'h0, 16'h0000,
           1, 0, OWN_IDLE, 21'h0, 1, 2'b11, 16'h0);
  endtask

  task automatic stepFclk();
    @(negedge fclk);
    expPhase = expPhase + 2'd1;
    checkOutput("phase", 32'({cbeg, post_cbeg, pre_cend, cend}), 32'(4'b1000 >> expPhase));
  endtask

  // Mid-cycle inputs are randomised so the bench sees whether the port was latched at cend.
  task automatic scramble();
    vid_slot    = 1'b0;
    cpu_req     = 1'b0;
    dma_req     = 1'b0;
    vid_addr    = 21'($urandom);
    cpu_addr    = 21'($urandom);
    cpu_rnw     = 1'($urandom);
    cpu_wrbsel  = 1'($urandom);
    cpu_wrdata  = 8'($urandom);
    dma_addr    = 21'($urandom);
    dma_rnw     = 1'($urandom);
    dma_wrdata  = 16'($urandom);
    dram_rddata = 16'($urandom);
  endtask

  task automatic retire(input vec_t r);
    dram_rddata = r.rdd;
    #1;
    checkOutput($sformatf("v%0d.dram_req", r.id), 32'(dram_req), 32'(r.eOwn != OWN_IDLE));
    checkOutput($sformatf("v%0d.cpu_strobe", r.id), 32'(cpu_strobe), 32'(r.eOwn == OWN_CPU && r.eRnw));
    checkOutput($sformatf("v%0d.vid_strobe", r.id), 32'(vid_strobe), 32'(r.eOwn == OWN_VID));
    checkOutput($sformatf("v%0d.dma_strobe", r.id), 32'(dma_strobe), 32'(r.eOwn == OWN_DMA && r.eRnw));
    if (r.eOwn != OWN_IDLE) begin
      checkOutput($sformatf("v%0d.dram_addr", r.id), 32'(dram_addr), 32'(r.eAddr));
      checkOutput($sformatf("v%0d.dram_rnw", r.id), 32'(dram_rnw), 32'(r.eRnw));
      checkOutput($sformatf("v%0d.dram_bsel", r.id), 32'(dram_bsel), 32'(r.eBsel));
      if (!r.eRnw)
        checkOutput($sformatf("v%0d.dram_wrdata", r.id), 32'(dram_wrdata), 32'(r.eWr));
      else
        expRddata = r.rdd;
    end
  endtask

  // Called at a cend: retires the cycle ending now, then drives the next decision.
  task automatic applyStimulus(input vec_t v);
    if (sb.size() != 0) retire(sb.pop_front());
    vid_slot = v.vid;   vid_addr = v.vaddr;
    cpu_req = v.creq;   cpu_rnw = v.crnw;   cpu_wrbsel = v.cbsel;
    cpu_addr = v.caddr; cpu_wrdata = v.cdata;
    dma_req = v.dreq;   dma_rnw = v.drnw;   dma_addr = v.daddr; dma_wrdata = v.ddata;
    #1;
    checkOutput($sformatf("v%0d.cpu_next", v.id), 32'(cpu_next), 32'(v.eNext));
    checkOutput($sformatf("v%0d.dma_ack", v.id), 32'(dma_ack), 32'(v.eAck));
    sb.push_back(v);
  endtask

  task automatic runCycle(input vec_t v);
    applyStimulus(v);
    stepFclk();
    checkOutput($sformatf("v%0d.rddata", v.id), 32'(rddata), 32'(expRddata));
    checkOutput($sformatf("v%0d.req_cbeg", v.id), 32'(dram_req), 32'(sb[0].eOwn != OWN_IDLE));
    scramble();
    stepFclk();
    #1;
    checkOutput($sformatf("v%0d.strobes_mid", v.id),
                32'({cpu_strobe, vid_strobe, dma_strobe, dma_ack}), 32'(0));
    scramble();
    stepFclk();
    checkOutput($sformatf("v%0d.req_pre", v.id), 32'(dram_req), 32'(sb[0].eOwn != OWN_IDLE));
    stepFclk();
  endtask

  initial begin
    rst_n = 1'b0;
    vid_slot = 0; vid_addr = '0; cpu_req = 0; cpu_rnw = 1; cpu_wrbsel = 0;
    cpu_addr = '0; cpu_wrdata = '0; dma_req = 0; dma_rnw = 1; dma_addr = '0;
    dma_wrdata = '0; dram_rddata = '0;
    expPhase = PH_CEND;
    expRddata = 16'h0;

    addIdle();
    addVec(0, 21'h0A0000, 1, 1, 0, 21'h012345, 8'h00, 0, 1, 21'h0, 16'h0, 16'hBEEF,
           1, 0, OWN_CPU, 21'h012345, 1, 2'b11, 16'h0);
    addVec(1, 21'h1ABCDE, 1, 1, 0, 21'h000111, 8'h00, 0, 1, 21'h0, 16'h0, 16'h1234,
           0, 0, OWN_VID, 21'h1ABCDE, 1, 2'b11, 16'h0);
    addVec(0, 21'h1ABCDE, 1, 1, 0, 21'h000111, 8'h00, 0, 1, 21'h0, 16'h0, 16'h5678,
           1, 0, OWN_CPU, 21'h000111, 1, 2'b11, 16'h0);
    addVec(0, 21'h0, 1, 0, 1, 21'h0F0F0F, 8'hA5, 0, 1, 21'h0, 16'h0, 16'hDEAD,
           1, 0, OWN_CPU, 21'h0F0F0F, 0, 2'b01, 16'hA5A5);
    addVec(0, 21'h0, 1, 0, 0, 21'h100000, 8'h3C, 0, 1, 21'h0, 16'h0, 16'hF00D,
           1, 0, OWN_CPU, 21'h100000, 0, 2'b10, 16'h3C3C);
    addVec(0, 21'h0, 0, 1, 0, 21'h0, 8'h00, 1, 1, 21'h1FFFFF, 16'h0, 16'hCAFE,
           1, 1, OWN_DMA, 21'h1FFFFF, 1, 2'b11, 16'h0);
    addVec(0, 21'h0, 0, 1, 0, 21'h0, 8'h00, 1, 0, 21'h000ABC, 16'h9876, 16'h4321,
           1, 1, OWN_DMA, 21'h000ABC, 0, 2'b11, 16'h9876);
    addVec(1, 21'h054321, 0, 1, 0, 21'h0, 8'h00, 1, 1, 21'h000222, 16'h0, 16'h7777,
           0, 0, OWN_VID, 21'h054321, 1, 2'b11, 16'h0);
    addIdle();
    // Continuous CPU + DMA: eight CPU wins, then one forced DMA grant.
    for (int i = 0; i < 8; i++)
      addVec(0, 21'h0, 1, 1, 0, 21'h000100 + 21'(i), 8'h00, 1, 1, 21'h1F0000 + 21'(i), 16'h0,
             16'(16'h1000 + i), 1, 0, OWN_CPU, 21'h000100 + 21'(i), 1, 2'b11, 16'h0);
    addVec(0, 21'h0, 1, 1, 0, 21'h000200, 8'h00, 1, 1, 21'h1F0100, 16'h0, 16'h2000,
           0, 1, OWN_DMA, 21'h1F0100, 1, 2'b11, 16'h0);
    addVec(0, 21'h0, 1, 1, 0, 21'h000300, 8'h00, 1, 1, 21'h1F0200, 16'h0, 16'h3000,
           1, 0, OWN_CPU, 21'h000300, 1, 2'b11, 16'h0);
    addIdle();
    // Video beats a forced DMA; the wait count keeps climbing and saturates.
    for (int i = 0; i < 17; i++)
      addVec(1, 21'h0A0000 + 21'(i), 1, 1, 0, 21'h000400, 8'h00, 1, 1, 21'h1F0300, 16'h0,
             16'(16'h4000 + i), 0, 0, OWN_VID, 21'h0A0000 + 21'(i), 1, 2'b11, 16'h0);
    addVec(0, 21'h0, 1, 0, 1, 21'h000500, 8'h11, 1, 0, 21'h1F0400, 16'hABCD, 16'h5000,
           0, 1, OWN_DMA, 21'h1F0400, 0, 2'b11, 16'hABCD);
    addIdle();
    addVec(0, 21'h0, 1, 1, 0, 21'h0ABCDE, 8'h00, 0, 1, 21'h0, 16'h0, 16'h6000,
           1, 0, OWN_CPU, 21'h0ABCDE, 1, 2'b11, 16'h0);
    addVec(0, 21'h0, 1, 1, 0, 21'h000777, 8'h00, 0, 1, 21'h0, 16'h0, 16'h2468,
           1, 0, OWN_CPU, 21'h000777, 1, 2'b11, 16'h0);
    addIdle();

    repeat (2) @(negedge fclk);
    #1;
    checkOutput("reset.phase", 32'({cbeg, post_cbeg, pre_cend, cend}), 32'(4'b0001));
    checkOutput("reset.dram_req", 32'(dram_req), 32'(0));
    checkOutput("reset.strobes", 32'({cpu_strobe, vid_strobe, dma_strobe, dma_ack}), 32'(0));
    checkOutput("reset.rddata", 32'(rddata), 32'(0));
    checkOutput("reset.cpu_next", 32'(cpu_next), 32'(1));
    @(negedge fclk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size() - 3; i++) runCycle(tbl[i]);

    // Abort a granted CPU read at post_cbeg.
    applyStimulus(tbl[tbl.size() - 3]);
    stepFclk();
    stepFclk();
    checkOutput("abort.req_before", 32'(dram_req), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort.req_async", 32'(dram_req), 32'(0));
    checkOutput("abort.phase_async", 32'({cbeg, post_cbeg, pre_cend, cend}), 32'(4'b0001));
    sb.delete();
    expRddata = 16'h0;
    expPhase = PH_CEND;
    @(negedge fclk);
    checkOutput("abort.rddata", 32'(rddata), 32'(expRddata));
    rst_n = 1'b1;
    #1;
    checkOutput("abort.phase_release", 32'({cbeg, post_cbeg, pre_cend, cend}), 32'(4'b0001));
    checkOutput("abort.owner_idle", 32'(dram_req), 32'(0));
    runCycle(tbl[tbl.size() - 2]);
    runCycle(tbl[tbl.size() - 1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
